fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Owns the fetch-stage program counter and sequences instruction fetches for the 64-bit RISC-V core.
//  Selects next PC: sequential +INSTR_BYTES, branch/jump redirect, or trap vector.
//  Issues fetch requests to instruction memory over a valid/ready handshake.
//  Applies hazard stalls and a halt/resume FSM. Replaces direct pc_in driving of the PC register.
// PARAMETERS
//  XLEN         64             PC / address width
//  RESET_VECTOR 64'h0          PC loaded on reset
//  TRAP_VECTOR  64'h100        PC loaded on trap_req or misaligned redirect
//  INSTR_BYTES  4              sequential PC increment
// PORTS
//  clk             in   1     rising-edge clock
//  reset           in   1     synchronous, active-high reset
//  stall           in   1     hazard hold; PC must not advance
//  redirect_valid  in   1     branch/jump taken this cycle
//  redirect_target in   XLEN  redirect destination
//  trap_req        in   1     exception; force PC to TRAP_VECTOR
//  halt_req        in   1     stop fetching (debug/ebreak)
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     imem accepts request
//  imem_req_addr   out  XLEN  fetch address (= pc_out)
//  pc_out          out  XLEN  current PC
//  fault           out  1     1-cycle pulse: misaligned redirect converted to trap
//  fetch_count     out  32    number of accepted fetches
//  state_out       out  2     FSM state (00 BOOT, 01 FETCH, 10 HALTED)
// BEHAVIOUR
//  Reset (sampled at posedge clk, overrides everything):
//   pc_out=RESET_VECTOR, state=BOOT, imem_req_valid=0, fault=0, fetch_count=0.
//  BOOT: single bubble cycle, imem_req_valid=0; next state FETCH unconditionally.
//  FETCH: imem_req_valid=1, imem_req_addr=pc_out.
//   Handshake fire = valid & ready. Priority per cycle, highest first:
//   1 trap_req -> pc<=TRAP_VECTOR; no advance.
//   2 redirect_valid & target[1:0]!=0 -> pc<=TRAP_VECTOR, fault<=1 next cycle.
//   3 redirect_valid (aligned) -> pc<=redirect_target.
//   4 halt_req -> state<=HALTED; pc unchanged.
//   5 stall -> pc held.
//   6 fire -> pc<=pc+INSTR_BYTES.
//   7 else hold.
//   fetch_count increments on every fire regardless of rows 1-5.
//   A request is committed only on fire.
//   While valid & !ready, addr is held stable unless row 1-3 changes pc; imem must tolerate this.
//  HALTED: imem_req_valid=0; stall and halt_req ignored.
//   trap_req -> pc<=TRAP_VECTOR, state FETCH.
//   aligned redirect -> pc<=target, state FETCH.
//   misaligned redirect -> pc<=TRAP_VECTOR, fault, state FETCH.
//  Arithmetic: pc+INSTR_BYTES modulo 2^XLEN; 64'hFFFF_FFFF_FFFF_FFFC -> 64'h0, no fault.
//   fetch_count wraps 32'hFFFF_FFFF -> 0.
//  fault: registered, asserted exactly one cycle after the offending redirect, else 0.
//  Reset mid-request: request is dropped, no handshake continuity; BOOT bubble is repeated.
//  Latency: redirect/trap visible on pc_out and imem_req_addr the cycle after it is sampled.
// TESTING
//  1 Reset, ready=1 held -> cycle1 valid=0 (BOOT); then addr 0,4,8,C on consecutive cycles; fetch_count=3 after addr C issued.
//  2 ready=0 for 3 cycles at pc=8 -> addr stays 8, fetch_count unchanged; ready=1 -> pc=C.
//  3 stall=1 with ready=1 at pc=10 -> pc held 10 but fetch_count increments each cycle; release -> 14.
//  4 redirect_valid+trap_req same cycle at pc=20 -> pc=100.
//    Redirect to 0x202 -> pc=100, fault=1 one cycle.
//    Redirect to 0x200 -> pc=200, fault=0.
//  5 halt_req at pc=40 -> HALTED, valid=0, stall ignored; redirect to 0x80 -> FETCH, addr=80.
//  6 Force pc=FFFF_FFFF_FFFF_FFFC via redirect, fire -> pc=0.
//    Assert reset during pending valid&!ready -> pc=RESET_VECTOR, BOOT bubble.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_sequencer                                              |
// | Description : Fetch-stage program counter and instruction fetch sequencer. |
// |               Chooses the next PC from the sequential increment, an        |
// |               aligned branch/jump redirect, or the trap vector. Issues     |
// |               fetches over a valid/ready handshake and runs a              |
// |               BOOT / FETCH / HALTED control FSM.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_sequencer #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
  parameter int              INSTR_BYTES  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_req,
  input  logic            halt_req,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  output logic [XLEN-1:0] pc_out,
  output logic            fault,
  output logic [31:0]     fetch_count,
  output logic [1:0]      state_out
);

  localparam logic [1:0]      c_st_boot   = 2'b00;
  localparam logic [1:0]      c_st_fetch  = 2'b01;
  localparam logic [1:0]      c_st_halted = 2'b10;
  localparam logic [XLEN-1:0] c_pc_incr   = XLEN'(INSTR_BYTES);

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_fault;
  logic [31:0]     r_fetch_count;

  logic [1:0]      w_state_next;
  logic [XLEN-1:0] w_pc_next;
  logic            w_fault_next;
  logic            w_req_valid;
  logic            w_fire;
  logic            w_misaligned;

  // A redirect whose target is not word aligned is turned into a trap.
  assign w_misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign w_fire       = w_req_valid && imem_req_ready;

  // State register: reset always restarts with the BOOT bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_boot;
    end else begin
      r_state <= w_state_next;
    end
  end

  // PC, fault pulse and accepted-fetch counter; the counter tracks every
  // handshake even when the PC itself is overridden or held that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_VECTOR;
      r_fault       <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      r_pc          <= w_pc_next;
      r_fault       <= w_fault_next;
      r_fetch_count <= r_fetch_count + {31'd0, w_fire};
    end
  end

  // Next state and next PC, in descending priority: trap, misaligned
  // redirect, aligned redirect, halt, stall, sequential advance on fire.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_fault_next = 1'b0;
    case (r_state)
      c_st_boot: begin
        w_state_next = c_st_fetch;
      end
      c_st_fetch: begin
        if (trap_req) begin
          w_pc_next = TRAP_VECTOR;
        end else if (w_misaligned) begin
          w_pc_next    = TRAP_VECTOR;
          w_fault_next = 1'b1;
        end else if (redirect_valid) begin
          w_pc_next = redirect_target;
        end else if (halt_req) begin
          w_state_next = c_st_halted;
        end else if (!stall && w_fire) begin
          w_pc_next = r_pc + c_pc_incr;
        end
      end
      c_st_halted: begin
        // Only a trap or a redirect wakes the fetcher; stall/halt are moot.
        if (trap_req) begin
          w_pc_next    = TRAP_VECTOR;
          w_state_next = c_st_fetch;
        end else if (w_misaligned) begin
          w_pc_next    = TRAP_VECTOR;
          w_fault_next = 1'b1;
          w_state_next = c_st_fetch;
        end else if (redirect_valid) begin
          w_pc_next    = redirect_target;
          w_state_next = c_st_fetch;
        end
      end
      default: begin
        w_state_next = c_st_boot;
      end
    endcase
  end

  // Fetch requests are presented only while in FETCH; the address is the PC.
  always_comb begin
    w_req_valid = (r_state == c_st_fetch);
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign pc_out         = r_pc;
  assign fault          = r_fault;
  assign fetch_count    = r_fetch_count;
  assign state_out      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_sequencer                                           |
// | Description : Scoreboard bench for fetch_sequencer. A driver issues        |
// |               directed then random stimulus and pushes the expected        |
// |               post-edge outputs from a behavioural model; a monitor pops   |
// |               and compares after every rising edge.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_sequencer;

  localparam logic [63:0] c_reset_vec = 64'h0;
  localparam logic [63:0] c_trap_vec  = 64'h100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_target = 64'h0;
  logic        trap_req = 1'b0;
  logic        halt_req = 1'b0;
  logic        imem_req_ready = 1'b0;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic [63:0] pc_out;
  logic        fault;
  logic [31:0] fetch_count;
  logic [1:0]  state_out;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .XLEN(64),
    .RESET_VECTOR(c_reset_vec),
    .TRAP_VECTOR(c_trap_vec),
    .INSTR_BYTES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .trap_req(trap_req),
    .halt_req(halt_req),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .pc_out(pc_out),
    .fault(fault),
    .fetch_count(fetch_count),
    .state_out(state_out)
  );

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic        fault;
    logic [31:0] cnt;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0 = BOOT, 1 = FETCH, 2 = HALTED (also the output code).
  logic [63:0] m_pc = 64'h0;
  int          m_mode = 0;
  logic [31:0] m_cnt = 32'h0;
  logic        m_fault = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, want, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and record what the DUT
  // must show after the following rising edge.
  task automatic step(input logic rst, input logic st, input logic rv,
                      input logic [63:0] rt, input logic tr, input logic hl,
                      input logic rdy);
    logic was_fetching;
    logic mis;
    @(negedge clk);
    reset           = rst;
    stall           = st;
    redirect_valid  = rv;
    redirect_target = rt;
    trap_req        = tr;
    halt_req        = hl;
    imem_req_ready  = rdy;

    was_fetching = (m_mode == 1);
    mis          = rv && ((rt % 64'd4) != 64'd0);
    if (rst) begin
      m_pc    = c_reset_vec;
      m_mode  = 0;
      m_cnt   = 32'h0;
      m_fault = 1'b0;
    end else begin
      if (was_fetching && rdy) m_cnt = m_cnt + 32'd1;
      m_fault = 1'b0;
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (tr)             m_pc = c_trap_vec;
        else if (mis)       begin m_pc = c_trap_vec; m_fault = 1'b1; end
        else if (rv)        m_pc = rt;
        else if (hl)        m_mode = 2;
        else if (!st && rdy) m_pc = m_pc + 64'd4;
      end else begin
        if (tr) begin
          m_pc   = c_trap_vec;
          m_mode = 1;
        end else if (rv) begin
          m_mode  = 1;
          m_pc    = mis ? c_trap_vec : rt;
          m_fault = mis;
        end
      end
    end
    exp_q.push_back('{valid: (m_mode == 1), pc: m_pc, fault: m_fault,
                      cnt: m_cnt, st: 2'(m_mode)});
  endtask

  // Monitor: compare every observable output shortly after each rising edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("valid",       {63'd0, imem_req_valid}, {63'd0, e.valid});
      chk("addr",        imem_req_addr, e.pc);
      chk("pc_out",      pc_out, e.pc);
      chk("fault",       {63'd0, fault}, {63'd0, e.fault});
      chk("fetch_count", {32'd0, fetch_count}, {32'd0, e.cnt});
      chk("state",       {62'd0, state_out}, {62'd0, e.st});
    end
  end

  initial begin : driver
    logic [63:0] tgt;
    // Reset, then sequential fetches 0,4,8 with ready high.
    step(1, 0, 0, 64'h0, 0, 0, 1);
    step(1, 0, 0, 64'h0, 0, 0, 1);
    step(0, 0, 0, 64'h0, 0, 0, 1);       // BOOT -> FETCH at 0
    step(0, 0, 0, 64'h0, 0, 0, 1);       // 4
    step(0, 0, 0, 64'h0, 0, 0, 1);       // 8
    // Back-pressure at 8.
    repeat (3) step(0, 0, 0, 64'h0, 0, 0, 0);
    step(0, 0, 0, 64'h0, 0, 0, 1);       // C
    step(0, 0, 0, 64'h0, 0, 0, 1);       // 10
    // Stall with ready: pc held, count advances.
    repeat (3) step(0, 1, 0, 64'h0, 0, 0, 1);
    step(0, 0, 0, 64'h0, 0, 0, 1);       // 14
    // Trap beats redirect, misaligned redirect faults, aligned redirect lands.
    step(0, 0, 1, 64'h200, 1, 0, 1);
    step(0, 0, 1, 64'h202, 0, 0, 1);
    step(0, 0, 1, 64'h200, 0, 0, 1);
    step(0, 0, 0, 64'h0, 0, 0, 1);
    // Halt at 0x40, stall/halt ignored while halted, redirect resumes.
    step(0, 0, 1, 64'h40, 0, 0, 1);
    step(0, 0, 0, 64'h0, 0, 1, 1);
    step(0, 1, 0, 64'h0, 0, 1, 1);
    step(0, 1, 0, 64'h0, 0, 0, 1);
    step(0, 0, 1, 64'h80, 0, 0, 1);
    step(0, 0, 0, 64'h0, 0, 0, 1);
    // Misaligned redirect from HALTED.
    step(0, 0, 0, 64'h0, 0, 1, 0);
    step(0, 0, 1, 64'h81, 0, 0, 0);
    // PC wrap at the top of the address space.
    step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1);
    step(0, 0, 0, 64'h0, 0, 0, 1);
    step(0, 0, 0, 64'h0, 0, 0, 1);
    // Reset while a request is pending without ready.
    step(0, 0, 0, 64'h0, 0, 0, 0);
    step(1, 0, 0, 64'h0, 0, 0, 0);
    step(0, 0, 0, 64'h0, 0, 0, 1);
    step(0, 0, 0, 64'h0, 0, 0, 1);
    step(0, 0, 0, 64'h0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       tgt = {$urandom, $urandom};
        1:       tgt = {$urandom, $urandom} & ~64'h3;
        2:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 | (64'($urandom_range(0, 3)) << 2);
        default: tgt = 64'($urandom_range(0, 255)) << 2;
      endcase
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0,
           tgt,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
